// File: rtl/multi_glitch_filter_pkg.sv
// Shared constants and width helpers for the multi-channel glitch filter.
`default_nettype none

package filter_pkg;

  localparam int DEFAULT_STABLE_CNT = 3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // The counter must be able to hold the value STABLE_CNT-1.
  function automatic int cnt_width(input int stable_cnt);
    int w;
    w = clog2(stable_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : filter_pkg

`default_nettype wire

// File: rtl/multi_glitch_filter_if.sv
// Data-side bundle of the glitch filter: enable, raw inputs and filtered status.
`default_nettype none

interface multi_glitch_filter_if #(
  parameter int CH = 4
);

  logic          p_en;
  logic [CH-1:0] sig_in;
  logic [CH-1:0] sig_out;
  logic [CH-1:0] busy;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  modport master (
    output p_en,
    output sig_in,
    input  sig_out,
    input  busy,
    input  rise,
    input  fall
  );

  modport slave (
    input  p_en,
    input  sig_in,
    output sig_out,
    output busy,
    output rise,
    output fall
  );

endinterface : multi_glitch_filter_if

`default_nettype wire

// File: rtl/multi_glitch_filter_chan.sv
// One filter channel: sample register, stability counter, output and status.
// Edge pulses are built only when FILTER_EDGE_EN is defined.
`default_nettype none

module filter_chan
  import filter_pkg::*;
#(
  parameter int   STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter logic INIT_BIT   = 1'b0
) (
  input  wire  clk_i,
  input  wire  rst_i,
  input  wire  en_i,
  input  wire  sig_i,
  output logic sig_o,
  output logic busy_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW     = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CNT - 1);

  logic          s_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (en_i && (s_q != out_q)) begin
      if (cnt_q == C_LAST) begin
        out_d = s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q    <= INIT_BIT;
      out_q  <= INIT_BIT;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      s_q    <= sig_i;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign sig_o  = out_q;
  assign busy_o = busy_q;

`ifdef FILTER_EDGE_EN
  logic rise_q, fall_q;

  // Pulses line up with the first cycle the output shows its new level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule : filter_chan

`default_nettype wire

// File: rtl/multi_glitch_filter.sv
// Multi-channel glitch filter top: CH independent filter_chan instances.
// Optional edge pulses controlled by the FILTER_EDGE_EN macro.
`default_nettype none

module multi_glitch_filter
  import filter_pkg::*;
#(
  parameter int          CH         = 4,
  parameter int          STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter logic [CH-1:0] INIT     = {CH{1'b0}}
) (
  input wire                   p_clk_in,
  input wire                   p_rst,
  multi_glitch_filter_if.slave bus
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    filter_chan #(
      .STABLE_CNT (STABLE_CNT),
      .INIT_BIT   (INIT[i])
    ) u_chan (
      .clk_i  (p_clk_in),
      .rst_i  (p_rst),
      .en_i   (bus.p_en),
      .sig_i  (bus.sig_in[i]),
      .sig_o  (bus.sig_out[i]),
      .busy_o (bus.busy[i]),
      .rise_o (bus.rise[i]),
      .fall_o (bus.fall[i])
    );
  end

endmodule : multi_glitch_filter

`default_nettype wire
